fifo_rd_streamer: RTL and testbench
===================================

// Module: fifo_rd_streamer
// PURPOSE
//  Read-side controller for the synchronous FIFO. Issues rd_en on the FIFO read
//  port and absorbs the FIFO's 1-cycle registered read latency. Presents the popped
//  words as a valid/ready stream through a 2-entry holding buffer, so a stalled
//  consumer never loses data. Sits between the FIFO read port and any
//  downstream consumer. Provides enable, flush/discard, a handshake counter and a
//  sticky underflow error.
// PARAMETERS
//  FIFO_WIDTH  16  data word width; must match the FIFO
//  CNT_WIDTH   16  width of the words_out counter
// PORTS
//  clk            in   1           clock; all logic on posedge
//  rst_n          in   1           async active-low reset
//  en             in   1           1 = stream words out; 0 = stop issuing reads
//  flush          in   1           1-cycle pulse: discard buffer, drain FIFO to empty
//  fifo_empty     in   1           FIFO empty flag (combinational from FIFO count)
//  fifo_underflow in   1           FIFO underflow flag (registered in the FIFO)
//  fifo_data_out  in   FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en
//  fifo_rd_en     out  1           FIFO read request
//  m_valid        out  1           stream word valid
//  m_data         out  FIFO_WIDTH  stream word; holds while m_valid && !m_ready
//  m_ready        in   1           consumer accepts when m_valid && m_ready
//  busy           out  1           1 while in FLUSH
//  words_out      out  CNT_WIDTH   count of completed m_valid&&m_ready handshakes
//  err_underflow  out  1           sticky: fifo_underflow was ever seen high
// BEHAVIOUR
//  Reset (async): state=IDLE, occ=0, rd_pend=0; all outputs 0.
//  Internal: occ (0..2) = buffered words; rd_pend = read issued last cycle.
//  pop  = m_valid && m_ready.
//  State machine:
//   IDLE : no reads issued. Go to RUN if en && !flush.
//   RUN  : go to IDLE if !en. Go to FLUSH if flush.
//   FLUSH: go to RUN/IDLE (per en) in the cycle after fifo_empty && !rd_pend.
//   flush takes priority over en from any state.
//  fifo_rd_en (combinational from regs, fifo_empty, m_ready):
//   RUN  : !fifo_empty && (occ + rd_pend - pop) < 2.
//   FLUSH: !fifo_empty.
//   IDLE : 0.
//   fifo_rd_en is never asserted while fifo_empty=1.
//  Capture: rd_pend <= fifo_rd_en. When rd_pend=1, fifo_data_out is written to the
//   buffer tail in the same edge as any pop. In FLUSH the data is discarded.
//   Leaving RUN for IDLE still captures an in-flight word; it is never dropped.
//  Output: m_valid = (occ!=0); m_data = buffer head (in order).
//   Simultaneous pop and capture keep occ unchanged.
//   Steady state with m_ready=1 is 1 word/cycle. First word appears 2 cycles after
//   rd_en (rd_en@T, captured@T+1, m_valid from T+1 register edge).
//  Flush: on the flush edge occ<=0 and m_valid drops next cycle. A pop coincident
//   with flush is still counted. Then drain the FIFO with discarded reads.
//  words_out: +1 per pop; wraps 2^CNT_WIDTH-1 -> 0.
//  err_underflow: set when fifo_underflow=1; cleared only by rst_n.
//  rst_n low mid-operation: everything returns to reset values immediately;
//   buffered and in-flight words are lost.
// TESTING
//  1. Reset: rst_n low with en=1 -> fifo_rd_en=0, m_valid=0, words_out=0, err_underflow=0.
//  2. FIFO holds 8 words 0x0001..0x0008, en=1, m_ready=1 -> 8 words in order,
//     one per cycle after 2-cycle latency, words_out=8, fifo_rd_en stops at empty.
//  3. 4 words, m_ready=0 -> exactly 2 reads issued, m_data=0x0001 held stable.
//     Then m_ready=1 -> remaining words arrive in order, none lost or duplicated.
//  4. 6 words, 2 popped, flush pulse -> m_valid=0 next cycle, busy=1 until FIFO
//     empty; words_out=2; then returns to RUN.
//  5. en dropped while rd_pend=1 -> in-flight word still appears on m_data, and no
//     further fifo_rd_en until en=1.
//  6. Force fifo_underflow=1 for 1 cycle -> err_underflow=1 held until rst_n.
//     Separately, 2^CNT_WIDTH pops -> words_out wraps to 0.

Source files
------------

// File: rtl/fifo_rd_streamer.sv
// Read-side streamer for the synchronous FIFO. It issues reads and hides the FIFO's
// one-cycle read latency behind a 2-entry holding buffer that feeds a valid/ready stream.
module fifo_rd_streamer #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  err_underflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [1:0]            occ;
    logic                  rd_pend;
    logic [FIFO_WIDTH-1:0] buf_head;
    logic [FIFO_WIDTH-1:0] buf_tail;
    logic                  pop;
    logic                  capture;
    logic [2:0]            fill;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_head;
    assign busy    = (state == FLUSH);
    assign pop     = m_valid && m_ready;

    // Words held or in flight after this edge; a read is only issued if it will fit.
    assign fill    = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};

    // Returning words are dropped while flushing, including one landing on the flush edge.
    assign capture = rd_pend && (state != FLUSH) && !flush;

    always_comb begin
        fifo_rd_en = 1'b0;
        case (state)
            RUN:     fifo_rd_en = !fifo_empty && (fill < 3'd2);
            FLUSH:   fifo_rd_en = !fifo_empty;
            default: fifo_rd_en = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = FLUSH;
        end else begin
            case (state)
                IDLE:    if (en) state_next = RUN;
                RUN:     if (!en) state_next = IDLE;
                FLUSH:   if (fifo_empty && !rd_pend) state_next = en ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_next;
            rd_pend <= fifo_rd_en;
        end
    end

    // Head is always the oldest word; a pop shifts the tail forward into the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({pop, capture})
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= fifo_data_out;
                    end else begin
                        buf_head <= fifo_data_out;
                    end
                end
                2'b10: begin
                    buf_head <= buf_tail;
                    occ      <= occ - 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        buf_head <= fifo_data_out;
                    end else begin
                        buf_tail <= fifo_data_out;
                    end
                    occ <= occ + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out     <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (pop) words_out <= words_out + CNT_WIDTH'(1);
            if (fifo_underflow) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a behavioural FIFO feeds the DUT and a queue of pushed
// words is the reference for the in-order, lossless stream the consumer should see.
module tb_fifo_rd_streamer;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty;
    logic          fifo_underflow = 1'b0;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;
    logic          busy;
    logic [CW-1:0] words_out;
    logic          err_underflow;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_total = 0;

    logic [W-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int bad_reads = 0;
    logic [W-1:0] exp_q[$];

    fifo_rd_streamer #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
        .words_out(words_out), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, empty flag straight from the pointers.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) begin
                bad_reads <= bad_reads + 1;
            end else begin
                fifo_data_out <= mem[rd_ptr % 1024];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [W-1:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(d);
    endtask

    task automatic step(input logic e, input logic f, input logic r);
        @(negedge clk);
        en = e;
        flush = f;
        m_ready = r;
        #1;
    endtask

    // Reports whether a handshake happens this cycle and the word the model expects.
    task automatic take(output logic hs, output logic [W-1:0] want);
        hs = m_valid && m_ready;
        want = 'x;
        if (hs && exp_q.size() > 0) want = exp_q.pop_front();
    endtask

    task automatic test_reset();
        logic hs;
        logic [W-1:0] want;
        rst_n = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        push(16'hA5A5);
        push(16'h5A5A);
        @(negedge clk);
        #1;
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (words_out !== '0) begin n_bad++; $display("[TB] FAIL reset_words_out: got %0d want 0", words_out); end
        n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", err_underflow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (10) begin
            step(1'b1, 1'b0, 1'b1);
            take(hs, want);
            if (hs) begin
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL reset_drain_data: got %h want %h", m_data, want); end
            end
        end
        exp_total += 2;
        n_cmp++; if (words_out !== CW'(exp_total)) begin n_bad++; $display("[TB] FAIL reset_drain_count: got %0d want %0d", words_out, exp_total); end
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_in_order();
        logic hs;
        logic [W-1:0] want;
        int first_rd = -1;
        int first_v = -1;
        int last_v = -1;
        int nv = 0;
        for (int i = 1; i <= 8; i++) push(W'(i));
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 1'b0, 1'b1);
            if (fifo_rd_en && first_rd < 0) first_rd = c;
            if (m_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nv++;
            end
            take(hs, want);
            if (hs) begin
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL order_data: got %h want %h", m_data, want); end
            end
        end
        exp_total += 8;
        n_cmp++; if (first_v - first_rd != 2) begin n_bad++; $display("[TB] FAIL order_latency: got %0d want 2", first_v - first_rd); end
        n_cmp++; if (nv != 8 || last_v - first_v != 7) begin n_bad++; $display("[TB] FAIL order_rate: got %0d words over %0d cycles want 8 over 8", nv, last_v - first_v + 1); end
        n_cmp++; if (words_out !== CW'(exp_total)) begin n_bad++; $display("[TB] FAIL order_count: got %0d want %0d", words_out, exp_total); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL order_left: got %0d undelivered want 0", exp_q.size()); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("[TB] FAIL order_rd_stop: got %b want 0", fifo_rd_en); end
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        logic hs;
        logic [W-1:0] want;
        int rd0;
        for (int i = 1; i <= 4; i++) push(W'(i));
        rd0 = rd_ptr;
        repeat (8) begin
            step(1'b1, 1'b0, 1'b0);
            if (m_valid) begin
                n_cmp++; if (m_data !== 16'h0001) begin n_bad++; $display("[TB] FAIL stall_hold: got %h want 0001", m_data); end
            end
        end
        n_cmp++; if (rd_ptr - rd0 != 2) begin n_bad++; $display("[TB] FAIL stall_reads: got %0d want 2", rd_ptr - rd0); end
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_valid: got %b want 1", m_valid); end
        repeat (12) begin
            step(1'b1, 1'b0, 1'b1);
            take(hs, want);
            if (hs) begin
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL stall_data: got %h want %h", m_data, want); end
            end
        end
        exp_total += 4;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL stall_left: got %0d undelivered want 0", exp_q.size()); end
        n_cmp++; if (words_out !== CW'(exp_total)) begin n_bad++; $display("[TB] FAIL stall_count: got %0d want %0d", words_out, exp_total); end
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        logic hs;
        logic [W-1:0] want;
        int pops = 0;
        int c = 0;
        for (int i = 0; i < 6; i++) push(W'($urandom));
        for (int k = 0; k < 20 && pops < 2; k++) begin
            step(1'b1, 1'b0, 1'b1);
            take(hs, want);
            if (hs) begin
                pops++;
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL flush_pre_data: got %h want %h", m_data, want); end
            end
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_valid: got %b want 0", m_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_busy: got %b want 1", busy); end
        while (busy && c < 30) begin
            step(1'b1, 1'b0, 1'b0);
            c++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_timeout: busy got %b want 0", busy); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_drain: fifo_empty got %b want 1", fifo_empty); end
        exp_total += 2;
        n_cmp++; if (words_out !== CW'(exp_total)) begin n_bad++; $display("[TB] FAIL flush_count: got %0d want %0d", words_out, exp_total); end
        exp_q.delete();
        push(16'hBEEF);
        repeat (6) begin
            step(1'b1, 1'b0, 1'b1);
            take(hs, want);
            if (hs) begin
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL flush_resume_data: got %h want %h", m_data, want); end
            end
        end
        exp_total += 1;
        n_cmp++; if (words_out !== CW'(exp_total)) begin n_bad++; $display("[TB] FAIL flush_resume_count: got %0d want %0d", words_out, exp_total); end
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_en_drop();
        logic hs;
        logic [W-1:0] want;
        int rd0;
        int got = 0;
        int extra_rd = 0;
        for (int i = 0; i < 3; i++) push(W'($urandom));
        rd0 = rd_ptr;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (fifo_rd_en) break;
        end
        step(1'b0, 1'b0, 1'b0);
        repeat (8) begin
            step(1'b0, 1'b0, 1'b1);
            if (fifo_rd_en) extra_rd++;
            take(hs, want);
            if (hs) begin
                got++;
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL endrop_data: got %h want %h", m_data, want); end
            end
        end
        n_cmp++; if (extra_rd != 0) begin n_bad++; $display("[TB] FAIL endrop_reads: got %0d reads while disabled want 0", extra_rd); end
        n_cmp++; if (got == 0 || got != rd_ptr - rd0) begin n_bad++; $display("[TB] FAIL endrop_inflight: got %0d delivered want %0d", got, rd_ptr - rd0); end
        repeat (10) begin
            step(1'b1, 1'b0, 1'b1);
            take(hs, want);
            if (hs) begin
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL endrop_resume_data: got %h want %h", m_data, want); end
            end
        end
        exp_total += 3;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL endrop_left: got %0d undelivered want 0", exp_q.size()); end
        n_cmp++; if (words_out !== CW'(exp_total)) begin n_bad++; $display("[TB] FAIL endrop_count: got %0d want %0d", words_out, exp_total); end
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic hs;
        logic [W-1:0] want;
        logic prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        for (int i = 0; i < 40; i++) push(W'($urandom));
        for (int c = 0; c < 600 && exp_q.size() > 0; c++) begin
            step(($urandom_range(0, 9) < 8), 1'b0, ($urandom_range(0, 9) < 6));
            if (prev_stall) begin
                n_cmp++; if (m_valid !== 1'b1 || m_data !== prev_data) begin n_bad++; $display("[TB] FAIL random_hold: got %b/%h want 1/%h", m_valid, m_data, prev_data); end
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            take(hs, want);
            if (hs) begin
                n_cmp++; if (m_data !== want) begin n_bad++; $display("[TB] FAIL random_data: got %h want %h", m_data, want); end
            end
        end
        step(1'b0, 1'b0, 1'b0);
        exp_total += 40;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL random_timeout: got %0d undelivered want 0", exp_q.size()); end
        n_cmp++; if (words_out !== CW'(exp_total)) begin n_bad++; $display("[TB] FAIL random_count: got %0d want %0d", words_out, exp_total); end
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_underflow_wrap();
        int pushed = 0;
        int popped = 0;
        int data_bad = 0;
        logic seen_max = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        fifo_underflow = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        fifo_underflow = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("[TB] FAIL underflow_set: got %b want 1", err_underflow); end
        repeat (5) step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("[TB] FAIL underflow_sticky: got %b want 1", err_underflow); end
        // Fill the buffer, then reset mid-operation; buffered words are lost.
        push(16'h1111);
        push(16'h2222);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_valid: got %b want 0", m_valid); end
        n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_err: got %b want 0", err_underflow); end
        n_cmp++; if (words_out !== '0) begin n_bad++; $display("[TB] FAIL midreset_count: got %0d want 0", words_out); end
        exp_q.delete();
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 70000 && popped < 65536; c++) begin
            while (wr_ptr - rd_ptr < 4 && pushed < 65536) begin
                mem[wr_ptr % 1024] = W'(pushed);
                wr_ptr = wr_ptr + 1;
                pushed++;
            end
            step(1'b1, 1'b0, 1'b1);
            if (popped == 65535 && !seen_max) begin
                seen_max = 1'b1;
                n_cmp++; if (words_out !== 16'hFFFF) begin n_bad++; $display("[TB] FAIL wrap_max: got %h want ffff", words_out); end
            end
            if (m_valid && m_ready) begin
                if (m_data !== W'(popped)) data_bad++;
                popped++;
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (popped != 65536) begin n_bad++; $display("[TB] FAIL wrap_timeout: got %0d pops want 65536", popped); end
        n_cmp++; if (data_bad != 0) begin n_bad++; $display("[TB] FAIL wrap_data: got %0d bad words want 0", data_bad); end
        n_cmp++; if (words_out !== '0) begin n_bad++; $display("[TB] FAIL wrap_count: got %0d want 0", words_out); end
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_in_order();
        test_stall();
        test_flush();
        test_en_drop();
        test_random();
        test_underflow_wrap();
        n_cmp++; if (bad_reads != 0) begin n_bad++; $display("[TB] FAIL read_while_empty: got %0d want 0", bad_reads); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
